serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial adder feeding LSB-first operand bit pairs into a combinational full adder each clock.
//  The full adder is built from two half_adder cells plus an OR gate.
//  Carry is held in a flop between bits. Trades WIDTH cycles of latency for one adder cell.
//  Sits downstream of operand capture, upstream of result consumers; start/done handshake.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock; all flops rising-edge
//  rst_n  in   1      asynchronous active-low reset
//  start  in   1      request; sampled only when busy=0
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in, captured on accepted start
//  busy   out  1      1 while shifting; start ignored when 1
//  done   out  1      1-cycle pulse: sum/cout just updated
//  sum    out  WIDTH  result (a+b+cin) mod 2^WIDTH
//  cout   out  1      carry-out of bit WIDTH-1
// BEHAVIOUR
//  Interface: one clock clk; reset rst_n is asynchronous, active-low.
//  Reset values: busy=0, done=0, sum=0, cout=0. Internal state: FSM=IDLE, cnt=0, carry=0.
//  FSM states:
//   IDLE: start=1 at edge E0 -> load a_sr=a, b_sr=b, carry=cin, cnt=0; go SHIFT.
//   SHIFT (edges E1..EWIDTH):
//    s,c = FA(a_sr[0], b_sr[0], carry)
//    sum_sr <= {s, sum_sr[WIDTH-1:1]}; a_sr,b_sr shift right; carry <= c; cnt++
//    On the edge where cnt==WIDTH-1:
//     sum <= {s, sum_sr[WIDTH-1:1]}, cout <= c, done <= 1; go DONE.
//   DONE: lasts one cycle; done=1, busy=0.
//    start=1 here is accepted as in IDLE (back-to-back; go SHIFT). Otherwise go IDLE.
//  Outputs:
//   busy=1 exactly in SHIFT.
//   Latency: start edge E0 -> done high after edge EWIDTH, i.e. WIDTH+1 edges.
//   Throughput: one add per WIDTH+1 cycles.
//  Holding rules:
//   sum/cout change only on the completion edge; held through IDLE and subsequent SHIFT.
//   start while busy=1: ignored, no effect on operands or count.
//   a/b/cin changes after acceptance: no effect (captured copies used).
//  Reset mid-operation (rst_n low in SHIFT): immediate return to reset values; no done pulse.
//   Next start after release begins a fresh add.
//  Width rules:
//   cnt is $clog2(WIDTH) bits.
//   Result equals low WIDTH bits of a+b+cin; cout = bit WIDTH.
// STRUCTURE
//  Shared include arith_defs.vh holds:
//   state localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
//   default WIDTH constant
//  Sub-module full_adder (a, b, cin, sum, cout):
//   two half_adder instances plus OR of their carries; purely combinational.
//  Top: FSM + counter, operand shift regs, carry flop, output regs.
// TESTING (WIDTH=8; check via $monitor and self-check)
//  1 reset: rst_n=0 -> busy=0 done=0 sum=8'h00 cout=0.
//  2 basic: a=8'h00 b=8'h00 cin=0 start -> done 9 edges later; sum=8'h00 cout=0.
//  3 carry chain: a=8'hFF b=8'h01 cin=0 -> sum=8'h00 cout=1.
//    Also a=8'hA5 b=8'h5A cin=1 -> sum=8'h00 cout=1.
//  4 start while busy: a=8'h12 b=8'h34, then pulse start at cycle 3 with a=8'hFF.
//    -> single done; sum=8'h46 cout=0.
//  5 back-to-back: start held high in DONE with a=8'h80 b=8'h80.
//    -> second done 9 edges later; sum=8'h00 cout=1.
//    Prior sum held until then.
//  6 reset mid-op: rst_n low at cycle 4 of SHIFT.
//    -> outputs 0 at once, no done.
//    Fresh a=8'h0F b=8'h01 -> sum=8'h10 cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the serial adder
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: full adder built from two half adders and an OR of their carries
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;
  half_adder ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
  half_adder ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full adder cell, start/done handshake
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, nxt;
  logic [WIDTH-2:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry, s, c;
  full_adder fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(s), .cout(c));
  // new sum bit enters at the MSB; after WIDTH shifts the LSB has arrived at bit 0
  assign nxt = {s, sum_sr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= nxt[WIDTH-1:1];
          carry  <= c;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= nxt;
            cout  <= c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with a done-driven scoreboard monitor
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic [8:0] exp_q[$];
  int         n_cmp = 0, n_err = 0, n_done = 0;
  logic [7:0] last_s = '0;
  logic       last_c = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with sum=%0h cout=%0b, expected none", sum, cout);
      end else begin
        chk("result{cout,sum}", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic go(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                    input logic [7:0] es, input logic ec, input bit b2b, input int poke);
    int k;
    int d0;
    d0 = n_done;
    if (!b2b) @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    exp_q.push_back({ec, es});
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
    k = 1;
    while (!done && k < 20) begin
      chk("held{cout,sum}", {23'd0, cout, sum}, {23'd0, last_c, last_s});
      chk("busy", {31'd0, busy}, 32'd1);
      if (k == poke) begin start = 1'b1; a = 8'hFF; end
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    chk("latency", k, 9);
    #1;
    chk("done_count", n_done - d0, 1);
    last_s = es;
    last_c = ec;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset{busy,done,cout,sum}", {21'd0, busy, done, cout, sum}, 32'd0);
    rst_n = 1'b1;
    go(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0);
    go(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0);
    go(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0, 0);
    go(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 3);
    repeat (12) @(negedge clk);
    go(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 0);
    go(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1, 0);
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    go(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 0, 0);
    go(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0);
    go(8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 0, 0);
    begin
      int d0;
      d0 = n_done;
      @(negedge clk);
      a = 8'h55; b = 8'h66; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("midop_reset{busy,done,cout,sum}", {21'd0, busy, done, cout, sum}, 32'd0);
      repeat (12) @(negedge clk);
      chk("no_done_after_reset", n_done - d0, 0);
      rst_n = 1'b1;
      last_s = 8'h00;
      last_c = 1'b0;
    end
    go(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, 0);
    repeat (12) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
